// File: rtl/rgmii_rx.sv
// RGMII DDR receive front end: nibble capture, byte assembly, preamble/SFD strip, framed byte stream.
// Optional FCS residue check is compiled in when RGMII_RX_CRC_CHECK_EN is defined.
module rgmii_rx #(
  parameter int unsigned MIN_PREAMBLE = 1,
  parameter int unsigned MAX_LEN      = 1522
) (
  input  logic        rx_clk,
  input  logic        rx_rst_n,
  input  logic [3:0]  rxd,
  input  logic        rx_ctl,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_last,
  output logic        rx_error,
  output logic        rx_crc_err,
  output logic [15:0] rx_len
);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

  localparam logic [15:0] LP_MAX_LEN = 16'(MAX_LEN);

  logic [3:0]  r_lo, r_hi;
  logic        r_dv, r_ctl_f;
  logic [7:0]  r_byte;
  logic        r_bdv, r_ber;

  state_t      r_state, w_state;
  logic [3:0]  r_pre_cnt, w_pre_cnt;
  logic [15:0] r_cnt;
  logic        r_err;
  logic [7:0]  r_hold;
  logic        r_hold_vld, w_hold_vld, r_hold_sof;
  logic        w_sfd, w_accept, w_emit, w_last, w_ovf, w_fin;
  logic        w_pre_ok, w_crc_bad;

  // Capture regs reset as "carrier active" so the FSM stays in DROP until a
  // real dv=0 byte arrives after reset release.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_lo   <= '0;
      r_dv   <= 1'b1;
      r_byte <= '0;
      r_bdv  <= 1'b1;
      r_ber  <= 1'b0;
    end else begin
      r_lo   <= rxd;
      r_dv   <= rx_ctl;
      r_byte <= {r_hi, r_lo};
      r_bdv  <= r_dv;
      r_ber  <= r_dv ^ r_ctl_f;
    end
  end

  always_ff @(negedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_hi    <= '0;
      r_ctl_f <= 1'b1;
    end else begin
      r_hi    <= rxd;
      r_ctl_f <= rx_ctl;
    end
  end

  assign w_pre_ok = 32'(r_pre_cnt) >= MIN_PREAMBLE;
  assign w_fin    = w_emit & w_last;

  // NOTE: every signal gets a default before the case so no latches are inferred.
  always_comb begin
    w_state    = r_state;
    w_pre_cnt  = r_pre_cnt;
    w_hold_vld = r_hold_vld;
    w_sfd      = 1'b0;
    w_accept   = 1'b0;
    w_emit     = 1'b0;
    w_last     = 1'b0;
    w_ovf      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_bdv) begin
          if (r_byte == 8'h55) begin
            w_state   = S_PREAMBLE;
            w_pre_cnt = 4'd1;
          end else begin
            w_state = S_DROP;
          end
        end
      end
      S_PREAMBLE: begin
        if (!r_bdv) begin
          w_state = S_IDLE;
        end else if (r_ber) begin
          w_state = S_DROP;
        end else if (r_byte == 8'h55) begin
          if (r_pre_cnt != 4'hF) w_pre_cnt = r_pre_cnt + 4'd1;
        end else if (r_byte == 8'hD5 && w_pre_ok) begin
          w_state    = S_DATA;
          w_sfd      = 1'b1;
          w_hold_vld = 1'b0;
        end else begin
          w_state = S_DROP;
        end
      end
      S_DATA: begin
        if (!r_bdv) begin
          w_emit     = r_hold_vld;
          w_last     = 1'b1;
          w_hold_vld = 1'b0;
          w_state    = S_IDLE;
        end else if (r_cnt == LP_MAX_LEN) begin
          // Overflow byte: close the frame on the held byte and discard the rest.
          w_emit     = r_hold_vld;
          w_last     = 1'b1;
          w_ovf      = 1'b1;
          w_hold_vld = 1'b0;
          w_state    = S_DROP;
        end else begin
          w_emit     = r_hold_vld;
          w_accept   = 1'b1;
          w_hold_vld = 1'b1;
        end
      end
      S_DROP: begin
        if (!r_bdv) w_state = S_IDLE;
      end
      default: w_state = S_DROP;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_state    <= S_DROP;
      r_pre_cnt  <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_hold_sof <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_sof     <= 1'b0;
      rx_last    <= 1'b0;
      rx_error   <= 1'b0;
      rx_crc_err <= 1'b0;
      rx_len     <= '0;
    end else begin
      r_state    <= w_state;
      r_pre_cnt  <= w_pre_cnt;
      r_hold_vld <= w_hold_vld;
      if (w_sfd) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else if (w_accept) begin
        r_cnt      <= (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
        r_err      <= r_err | r_ber;
        r_hold     <= r_byte;
        r_hold_sof <= (r_cnt == 16'd0);
      end
      rx_valid   <= w_emit;
      rx_data    <= w_emit ? r_hold : 8'h00;
      rx_sof     <= w_emit & r_hold_sof;
      rx_last    <= w_fin;
      rx_error   <= w_fin & (r_err | w_ovf | w_crc_bad);
      rx_crc_err <= w_fin & w_crc_bad;
      rx_len     <= w_fin ? r_cnt : 16'd0;
    end
  end

`ifdef RGMII_RX_CRC_CHECK_EN
  localparam logic [31:0] LP_RESIDUE = 32'hC704DD7B;

  logic [31:0] r_crc, w_crc_rev;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'd0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n)     r_crc <= '1;
    else if (w_sfd)    r_crc <= '1;
    else if (w_accept) r_crc <= crc_byte(r_crc, r_byte);
  end

  // The register is kept LSB-first; the residue constant is in MSB-first order.
  always_comb begin
    for (int i = 0; i < 32; i++) w_crc_rev[i] = r_crc[31-i];
  end

  assign w_crc_bad = (w_crc_rev != LP_RESIDUE) || (r_cnt < 16'd4);
`else
  assign w_crc_bad = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_rx.sv
// Scoreboard bench for rgmii_rx: drives DDR frames, queues expected bytes, compares
// data, markers, status and latency as the DUT emits them.
module tb_rgmii_rx;

  localparam int MAX_LEN = 1522;
`ifdef RGMII_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        rx_clk = 1'b0;
  logic        rx_rst_n;
  logic [3:0]  rxd;
  logic        rx_ctl;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_last, rx_error, rx_crc_err;
  logic [15:0] rx_len;

  rgmii_rx #(.MIN_PREAMBLE(1), .MAX_LEN(MAX_LEN)) dut (
    .rx_clk    (rx_clk),
    .rx_rst_n  (rx_rst_n),
    .rxd       (rxd),
    .rx_ctl    (rx_ctl),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_sof    (rx_sof),
    .rx_last   (rx_last),
    .rx_error  (rx_error),
    .rx_crc_err(rx_crc_err),
    .rx_len    (rx_len)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic [7:0]  data;
    logic        sof;
    logic        last;
    logic        err;
    logic        crc_err;
    logic [15:0] len;
    int          cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] frm[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;

  always @(posedge rx_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'd0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Output monitor: every emitted byte must match the head of the scoreboard.
  always @(negedge rx_clk) begin
    exp_t e;
    if (rx_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(rx_data), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("data", 32'(rx_data), 32'(e.data));
        check("sof", 32'(rx_sof), 32'(e.sof));
        check("last", 32'(rx_last), 32'(e.last));
        check("latency", 32'(cyc), 32'(e.cyc));
        if (e.last) begin
          check("error", 32'(rx_error), 32'(e.err));
          check("crc_err", 32'(rx_crc_err), 32'(e.crc_err));
          check("len", 32'(rx_len), 32'(e.len));
        end
      end
    end
  end

  // k = posedge at which this byte's low nibble is sampled.
  task automatic drive_byte(input logic [7:0] b, input logic dv, input logic er, output int k);
    @(negedge rx_clk); #1;
    rxd    = b[3:0];
    rx_ctl = dv;
    k      = cyc + 1;
    @(posedge rx_clk); #1;
    rxd    = b[7:4];
    rx_ctl = dv ^ er;
  endtask

  task automatic idle(input int n);
    int k;
    for (int i = 0; i < n; i++) drive_byte(8'h00, 1'b0, 1'b0, k);
  endtask

  task automatic build_frame(input int n_payload, input bit add_fcs);
    logic [31:0] c;
    frm.delete();
    c = '1;
    for (int i = 0; i < n_payload; i++) begin
      frm.push_back(8'($urandom_range(0, 255)));
      c = crc_upd(c, frm[i]);
    end
    c = ~c;
    if (add_fcs) begin
      frm.push_back(c[7:0]);
      frm.push_back(c[15:8]);
      frm.push_back(c[23:16]);
      frm.push_back(c[31:24]);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_data"}, 32'(rx_data), 32'd0);
    check({tag, "_flags"}, 32'({rx_sof, rx_last, rx_error, rx_crc_err}), 32'd0);
    check({tag, "_len"}, 32'(rx_len), 32'd0);
  endtask

  // Preamble + SFD + frm + one dv=0 byte. er_idx / rst_at < 0 disable those events.
  task automatic send_frame(input int er_idx, input int rst_at);
    int          k, n, n_del;
    logic        crc_bad, err_any;
    logic [31:0] c;
    exp_t        e;
    n     = frm.size();
    n_del = (n > MAX_LEN) ? MAX_LEN : n;
    c     = '1;
    for (int i = 0; i < n_del; i++) c = crc_upd(c, frm[i]);
    crc_bad = CRC_EN && ((c != 32'hDEBB20E3) || (n_del < 4));
    err_any = (er_idx >= 0 && er_idx < n_del) || (n > MAX_LEN) || crc_bad;
    for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b1, 1'b0, k);
    drive_byte(8'hD5, 1'b1, 1'b0, k);
    for (int i = 0; i < n; i++) begin
      if (rst_at >= 0 && i == rst_at) begin
        #2 rx_rst_n = 1'b0;
        sb.delete();
        #1 check_outputs_zero("rst_mid");
      end
      if (rst_at >= 0 && i == rst_at + 2) rx_rst_n = 1'b1;
      drive_byte(frm[i], 1'b1, (i == er_idx), k);
      if (i < n_del && (rst_at < 0 || i < rst_at)) begin
        e.data    = frm[i];
        e.sof     = (i == 0);
        e.last    = (i == n_del - 1);
        e.err     = err_any;
        e.crc_err = crc_bad;
        e.len     = 16'(n_del);
        e.cyc     = k + 3;
        sb.push_back(e);
      end
    end
    drive_byte(8'h00, 1'b0, 1'b0, k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rx_rst_n = 1'b0;
    rxd      = 4'h0;
    rx_ctl   = 1'b0;
    repeat (3) @(posedge rx_clk);
    #2 check_outputs_zero("reset");
    rx_rst_n = 1'b1;
    idle(3);

    // Good 64-byte frame.
    build_frame(60, 1'b1);
    send_frame(-1, -1);
    // Same frame with RX_ER on byte 20.
    send_frame(20, -1);

    // Preamble without SFD: nothing delivered.
    drive_byte(8'h55, 1'b1, 1'b0, k);
    drive_byte(8'h55, 1'b1, 1'b0, k);
    drive_byte(8'hAA, 1'b1, 1'b0, k);
    drive_byte(8'hD5, 1'b1, 1'b0, k);
    drive_byte(8'h12, 1'b1, 1'b0, k);
    idle(1);
    build_frame(40, 1'b1);
    send_frame(-1, -1);

    // Reset pulse in the middle of byte 30, then a clean frame.
    build_frame(60, 1'b1);
    send_frame(-1, 30);
    build_frame(46, 1'b1);
    send_frame(-1, -1);

    // One corrupted payload bit.
    build_frame(60, 1'b1);
    frm[10] = frm[10] ^ 8'h04;
    send_frame(-1, -1);

    // Overflow: 1600 bytes truncated at MAX_LEN.
    build_frame(1596, 1'b1);
    send_frame(-1, -1);

    // Zero-length frame, one-byte frame, then two frames with a one-cycle gap.
    frm.delete();
    send_frame(-1, -1);
    frm.delete();
    frm.push_back(8'hA5);
    send_frame(-1, -1);
    build_frame(20, 1'b1);
    send_frame(-1, -1);
    build_frame(30, 1'b1);
    send_frame(-1, -1);

    idle(2);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge rx_clk);
    @(negedge rx_clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
